onchip_mem_reader: RTL and testbench

Sequential read engine directly upstream of the 32-bit single-port on-chip memory (17-bit word address, 1-cycle read latency, 100000 words). On a command it drives the memory's Avalon slave port to read `length` consecutive words from `base_addr` and emits them as a valid/ready stream with an end-of-transfer marker. A small output FIFO absorbs the memory's fixed latency so downstream backpressure never loses data.

---
 rtl/onchip_reader_pkg.sv | 20 ++
 rtl/onchip_reader_fifo.sv | 69 ++++++
 rtl/onchip_mem_reader.sv | 151 +++++++++++++++
 tb/tb_onchip_mem_reader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_reader_pkg.sv
// Shared widths, FSM state type and address helper for the on-chip memory reader.
package onchip_reader_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } rd_state_t;

  // Next sequential word address, wrapping from depth-1 back to 0.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a,
                                                 input int unsigned       depth);
    return (a == ADDR_W'(depth - 1)) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/onchip_reader_fifo.sv
// Show-ahead FIFO holding {last, data}; head is visible while valid is high.
module onchip_reader_fifo
  import onchip_reader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = DATA_W + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          valid_q, valid_d;

  // Pointer/count update; simultaneous push and pop leave the count unchanged.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    valid_d = (cnt_d != '0);
  end

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign valid = valid_q;
  assign count = cnt_q;

endmodule

// File: rtl/onchip_mem_reader.sv
// Sequential read engine: reads `length` words from on-chip memory and streams them out.
module onchip_mem_reader
  import onchip_reader_pkg::*;
#(
  parameter int MEM_DEPTH  = 100000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic              cs_q, cs_d;
  logic              cs_last_q, cs_last_d;
  logic              infl_q, infl_d;
  logic              infl_last_q, infl_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CW-1:0]     fifo_count;
  logic              fifo_valid;
  logic [DATA_W:0]   fifo_head;
  logic              pop;
  logic              credit_ok;

  assign pop = fifo_valid & out_ready;
  // Words already buffered, requested this cycle, or returning this cycle all hold a slot.
  assign credit_ok = (int'(fifo_count) + int'(cs_q) + int'(infl_q)) < FIFO_DEPTH;

  // FSM next-state, request issue and completion decisions.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    cs_d        = 1'b0;
    cs_last_d   = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    infl_d      = cs_q;
    infl_last_d = cs_last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d     = ST_READ;
            busy_d      = 1'b1;
            cs_d        = 1'b1;
            addr_d      = base_addr;
            remaining_d = length - 1'b1;
            cs_last_d   = (length == ADDR_W'(1));
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (remaining_q == '0) begin
          state_d = ST_DRAIN;
        end else if (credit_ok) begin
          cs_d        = 1'b1;
          addr_d      = addr_inc(addr_q, MEM_DEPTH);
          remaining_d = remaining_q - 1'b1;
          cs_last_d   = (remaining_q == ADDR_W'(1));
          if (remaining_q == ADDR_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Finish once the final word leaves the FIFO on this edge.
        if (!cs_q && !infl_q && (fifo_count == {{(CW-1){1'b0}}, pop})) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and registered outputs; reset abandons any transfer without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      cs_q        <= 1'b0;
      cs_last_q   <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      cs_q        <= cs_d;
      cs_last_q   <= cs_last_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  onchip_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (infl_q),
    .push_data ({infl_last_q, mem_readdata}),
    .pop       (pop),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign busy           = busy_q;
  assign done           = done_q;
  assign mem_address    = addr_q;
  assign mem_chipselect = cs_q;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign out_data       = fifo_head[DATA_W-1:0];
  assign out_last       = fifo_head[DATA_W];
  assign out_valid      = fifo_valid;

endmodule

// File: tb/tb_onchip_mem_reader.sv
// Randomized bench for onchip_mem_reader with a queue-based expected stream.
module tb_onchip_mem_reader;

  localparam int MEM_DEPTH  = 100000;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [16:0] base_addr;
  logic [16:0] length;
  logic        busy;
  logic        done;
  logic [16:0] mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic        mem_clken;
  logic [31:0] mem_readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  onchip_mem_reader #(
    .MEM_DEPTH  (MEM_DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory contents: word at address a is a XOR key (key = 0 gives word n = n).
  logic [31:0] key = 32'h0;
  function automatic logic [31:0] word_at(input logic [16:0] a);
    return {15'h0, a} ^ key;
  endfunction

  // One-cycle read latency memory.
  always @(posedge clk) mem_readdata <= word_at(mem_address);

  // Expected behaviour of one command: address sequence and output words.
  logic [16:0] addr_q[$];
  logic [31:0] exp_q[$];
  int  issued = 0, popped = 0, done_cnt = 0;
  int  done_cyc = -1, last_hs_cyc = -1, first_valid_cyc = -1;
  int  cyc = 0;
  bit  mon_en = 1'b0;

  // Observer sampling at the falling edge.
  always @(negedge clk) begin
    logic [31:0] ew;
    cyc++;
    if (mon_en) begin
      if (mem_chipselect) begin
        issued++;
        if (addr_q.size() == 0) chk("extra_req", addr_q.size(), 1);
        else chk("req_addr", mem_address, addr_q.pop_front());
        chk("credit", (issued - popped) <= FIFO_DEPTH, 1);
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", exp_q.size(), 1);
        end else begin
          ew = exp_q.pop_front();
          chk("data", out_data, ew);
          chk("last", out_last, exp_q.size() == 0);
        end
        popped++;
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic run_xfer(input int b, input int len, input bit rnd_ready, input bit poke);
    int e_cyc;
    addr_q.delete();
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      addr_q.push_back(17'((b + i) % MEM_DEPTH));
      exp_q.push_back(word_at(17'((b + i) % MEM_DEPTH)));
    end
    issued = 0; popped = 0; done_cnt = 0;
    done_cyc = -1; last_hs_cyc = -1; first_valid_cyc = -1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 17'(b); length = 17'(len); out_ready = 1'b1;
    @(posedge clk);
    e_cyc = cyc;
    #1 start = 1'b0;
    @(negedge clk);
    chk("busy_rise", busy, len != 0);
    for (int k = 0; k < 600 && done_cnt == 0; k++) begin
      @(posedge clk); #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && k == 2) begin
        start = 1'b1;
        base_addr = 17'((b + 100) % MEM_DEPTH);
        length = 17'(len + 5);
      end else begin
        start = 1'b0;
      end
    end
    out_ready = 1'b1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("done_count", done_cnt, 1);
    chk("words", popped, len);
    chk("reqs", issued, len);
    chk("exp_left", exp_q.size(), 0);
    chk("busy_end", busy, 0);
    if (len == 0) begin
      chk("done_len0", done_cyc, e_cyc + 1);
      chk("no_valid", first_valid_cyc, -1);
    end else begin
      chk("done_after_last", done_cyc, last_hs_cyc + 1);
      if (!rnd_ready) begin
        chk("first_valid", first_valid_cyc, e_cyc + 3);
        chk("throughput", last_hs_cyc, e_cyc + 2 + len);
      end
    end
    mon_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_cs", mem_chipselect, 0);
    chk("rst_addr", mem_address, 0);
    chk("const_write", mem_write, 0);
    chk("const_be", mem_byteenable, 4'hF);
    chk("const_clken", mem_clken, 1);
    @(posedge clk); #1 reset = 1'b0;

    // Basic read, word n = n.
    key = 32'h0;
    run_xfer(16, 4, 1'b0, 1'b0);

    // Address wrap at the top of memory.
    key = $urandom;
    run_xfer(99998, 4, 1'b0, 1'b0);

    // Random backpressure.
    key = $urandom;
    run_xfer(int'($urandom_range(0, MEM_DEPTH - 1)), 16, 1'b1, 1'b0);

    // Zero-length command.
    run_xfer(50, 0, 1'b0, 1'b0);

    // Start while busy is ignored.
    key = $urandom;
    run_xfer(200, 8, 1'b1, 1'b1);

    // Reset in the middle of a transfer with words buffered.
    key = $urandom;
    @(posedge clk); #1;
    out_ready = 1'b0; start = 1'b1; base_addr = 17'd500; length = 17'd20;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_valid", out_valid, 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cs", mem_chipselect, 0);
    chk("mid_rst_addr", mem_address, 0);
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_valid", out_valid, 0);
    end
    run_xfer(1000, 5, 1'b0, 1'b0);

    // Random commands.
    for (int t = 0; t < 6; t++) begin
      key = $urandom;
      run_xfer(int'($urandom_range(0, MEM_DEPTH - 1)), int'($urandom_range(1, 20)),
               1'($urandom_range(0, 1)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
